// File: rtl/synchronous_fifo.sv
// synchronous_fifo: single-clock FIFO with registered read data and full/empty flags
module synchronous_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_signal,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] data_input,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic                  full_f,
  output logic                  empty_f
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_output_q, data_output_d;
  logic wr_en, rd_en;
  assign empty_f = wr_ptr_q == rd_ptr_q;
  assign full_f = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) && (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign data_output = data_output_q;
  always_comb begin
    wr_en = write_enable && !full_f;
    rd_en = read_enable && !empty_f;
    wr_ptr_d = wr_en ? wr_ptr_q + (ADDR_WIDTH+1)'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + (ADDR_WIDTH+1)'(1) : rd_ptr_q;
    data_output_d = rd_en ? mem[rd_ptr_q[ADDR_WIDTH-1:0]] : data_output_q;
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_input;
  end
  always_ff @(posedge clk or negedge reset_signal) begin
    if (!reset_signal) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data_output_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data_output_q <= data_output_d;
    end
  end
endmodule

// File: tb/tb_synchronous_fifo.sv
// tb_synchronous_fifo: directed self-checking bench for synchronous_fifo
module tb_synchronous_fifo;
  logic clk = 1'b0;
  logic reset_signal = 1'b0;
  logic write_enable = 1'b0;
  logic read_enable = 1'b0;
  logic [31:0] data_input = '0;
  logic [31:0] data_output;
  logic full_f, empty_f;
  int checks = 0;
  int errors = 0;
  synchronous_fifo dut (
    .clk(clk),
    .reset_signal(reset_signal),
    .write_enable(write_enable),
    .data_input(data_input),
    .read_enable(read_enable),
    .data_output(data_output),
    .full_f(full_f),
    .empty_f(empty_f)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step;
    chk("rst_dout", data_output, 0);
    chk("rst_empty", 32'(empty_f), 1);
    chk("rst_full", 32'(full_f), 0);
    reset_signal = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 32; i++) begin
        write_enable = 1'b1;
        data_input = 32'(p * 256 + i);
        step;
        chk("fill_empty", 32'(empty_f), 0);
        chk("fill_full", 32'(full_f), 32'(i == 31));
      end
      data_input = 99;
      step;
      chk("over_full", 32'(full_f), 1);
      write_enable = 1'b0;
      read_enable = 1'b1;
      for (int i = 0; i < 32; i++) begin
        step;
        chk("drain_dout", data_output, 32'(p * 256 + i));
        chk("drain_full", 32'(full_f), 0);
        chk("drain_empty", 32'(empty_f), 32'(i == 31));
      end
      step;
      chk("under_dout", data_output, 32'(p * 256 + 31));
      chk("under_empty", 32'(empty_f), 1);
      read_enable = 1'b0;
    end
    write_enable = 1'b1;
    read_enable = 1'b1;
    data_input = 32'hAAAA;
    step;
    chk("se_dout", data_output, 32'h11F);
    chk("se_empty", 32'(empty_f), 0);
    read_enable = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      data_input = 32'(32'hB0 + i);
      step;
    end
    read_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_input = 32'(32'hC0 + i);
      step;
      chk("sim_dout", data_output, i == 0 ? 32'hAAAA : i < 5 ? 32'(32'hB0 + i) : 32'(32'hC0 + i - 5));
      chk("sim_empty", 32'(empty_f), 0);
      chk("sim_full", 32'(full_f), 0);
    end
    write_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("occ_dout", data_output, 32'(32'hC5 + i));
      chk("occ_empty", 32'(empty_f), 32'(i == 4));
    end
    read_enable = 1'b0;
    write_enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      data_input = 32'(32'h200 + i);
      step;
    end
    chk("sf_full0", 32'(full_f), 1);
    read_enable = 1'b1;
    data_input = 32'h999;
    step;
    chk("sf_dout", data_output, 32'h200);
    chk("sf_full", 32'(full_f), 0);
    write_enable = 1'b0;
    for (int i = 1; i < 32; i++) begin
      step;
      chk("sf_drain", data_output, 32'(32'h200 + i));
    end
    chk("sf_empty", 32'(empty_f), 1);
    read_enable = 1'b0;
    write_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_input = 32'(32'h300 + i);
      step;
    end
    write_enable = 1'b0;
    chk("mr_pre_empty", 32'(empty_f), 0);
    #2 reset_signal = 1'b0;
    #1;
    chk("mr_empty", 32'(empty_f), 1);
    chk("mr_full", 32'(full_f), 0);
    chk("mr_dout", data_output, 0);
    step;
    reset_signal = 1'b1;
    read_enable = 1'b1;
    step;
    chk("mr_rd_dout", data_output, 0);
    chk("mr_rd_empty", 32'(empty_f), 1);
    read_enable = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/synchronous_fifo.md
Name: synchronous_fifo

Overview:
- Single-clock first-in/first-out buffer, 32 entries by 32 bits by default.
- Decouples a producer and a consumer running in the same clock domain.
- Write and read requests are qualified internally against full and empty status.
- Read data is registered.

Parameters:
- DATA_WIDTH, 32, width of each stored word and of data_input/data_output.
- DEPTH, 32, number of storage entries; must be a power of two ≥ 2.
- ADDR_WIDTH, log2(DEPTH) = 5, storage address width; pointers are ADDR_WIDTH+1 bits.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset_signal  input  1  asynchronous, active-low reset.
- write_enable  input  1  write request for the current cycle.
- data_input  input  DATA_WIDTH  word to store when the write is accepted.
- read_enable  input  1  read request for the current cycle.
- data_output  output  DATA_WIDTH  registered read data.
- full_f  output  1  high when DEPTH words are stored.
- empty_f  output  1  high when 0 words are stored.

Behaviour:
- Clocking and reset:
  - One clock, clk; all state updates on its rising edge.
  - reset_signal is asynchronous and active-low.
  - Assertion (low) immediately clears write pointer, read pointer and data_output to 0, and forces empty_f=1, full_f=0.
  - Release is sampled on the next rising edge.
  - Storage array contents are not reset.
  - Reset mid-operation discards all stored words; the FIFO is empty after release.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide.
  - The low ADDR_WIDTH bits address storage.
  - The MSB toggles on each wrap past DEPTH-1 → 0.
- Status flags:
  - empty_f = (wr_ptr == rd_ptr).
  - full_f = (low bits equal) AND (MSBs differ).
  - Both are combinational from the registered pointers, so they reflect the state after the most recent edge.
- Write:
  - Accepted when write_enable=1 and full_f=0, both sampled at the rising edge.
  - mem[wr_ptr low bits] ← data_input, then wr_ptr increments.
  - Write while full is ignored: no storage change, no pointer change, no error flag.
- Read:
  - Accepted when read_enable=1 and empty_f=0 at the rising edge.
  - data_output ← mem[rd_ptr low bits], then rd_ptr increments.
  - Latency is one edge: the word is valid on data_output after the accepting edge.
  - Read while empty is ignored: data_output holds its previous value and rd_ptr is unchanged.
  - data_output holds its last value whenever no read is accepted.
- Simultaneous write and read:
  - Each is qualified independently against the pre-edge flags.
  - Neither full nor empty: both occur and occupancy is unchanged.
  - Empty: only the write occurs; the read is ignored, and the written word is not bypassed to the output.
  - Full: only the read occurs; the write is dropped.
- Ordering: words emerge in exactly the order accepted, across any number of pointer wraps.
- Flag timing:
  - The DEPTH-th accepted write from empty raises full_f at that edge.
  - The first accepted read from full lowers full_f.
  - The last accepted read lowers occupancy to 0 and raises empty_f at that edge.

Test Plan:
- Reset: hold reset_signal=0 for one cycle, then release → data_output=0, empty_f=1, full_f=0. Assert reset asynchronously mid-cycle → flags change before the next edge.
- Fill: write_enable=1 for 32 cycles, data_input=0..31 → empty_f falls after the first edge; full_f=1 after the 32nd edge. A 33rd write (data 99) is ignored and full_f stays 1.
- Drain: read_enable=1 for 32 cycles from full → data_output shows 0,1,…,31, one per edge. full_f falls after the first read; empty_f=1 after the 32nd. A further read leaves data_output=31.
- Wrap: refill with 0..31 after the drain, then read 32 → sequence 0..31 again and full_f asserts identically; this exercises pointer MSB wrap.
- Simultaneous: with 5 words stored, assert both enables for 10 cycles → occupancy stays 5 and output order is preserved. When full, both enables → read only, full_f drops. When empty, both enables → write only, data_output unchanged, empty_f drops.
- Reset mid-operation: write 10 words, pull reset low → empty_f=1 immediately. After release, a read is ignored and data_output=0.
